jtmx5k_snd_comm: RTL

JTMX5K_SND_COMM -- requirements
Module: jtmx5k_snd_comm

---
 rtl/jtmx5k_pkg.sv | 17 +
 rtl/jtmx5k_cmd_fifo.sv | 63 ++++++
 rtl/jtmx5k_snd_comm.sv | 86 ++++++++
 3 files changed

// File: rtl/jtmx5k_pkg.sv
// Shared definitions for the jtmx5k sound-command path: default FIFO depth and
// the interrupt FSM encoding used by the sound CPU interface.
package jtmx5k_pkg;

  localparam int SND_DEPTH_DEF = 4;
  localparam int SND_DATA_W    = 8;

  typedef enum logic [1:0] {
    INT_IDLE  = 2'd0,
    INT_REQ   = 2'd1,
    INT_ACKED = 2'd2
  } int_state_e;

  // Byte shown to the sound CPU when nothing is queued.
  localparam logic [SND_DATA_W-1:0] SND_EMPTY_BYTE = 8'hFF;

endpackage

// File: rtl/jtmx5k_cmd_fifo.sv
// Command FIFO between the main CPU and the sound CPU: storage, wrapping
// pointers, occupancy and the sticky overrun flag.
module jtmx5k_cmd_fifo
  import jtmx5k_pkg::*;
#(
  parameter int DEPTH = SND_DEPTH_DEF
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      push,
  input  logic                      pop,
  input  logic [SND_DATA_W-1:0]     din,
  output logic [SND_DATA_W-1:0]     dout,
  output logic [$clog2(DEPTH):0]    level,
  output logic                      overrun
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [SND_DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]         level_q,  level_d;
  logic                  overrun_q, overrun_d;
  logic                  pop_ok, push_ok, empty, full;

  // A pop on empty is ignored; a push on full only lands if a pop frees a slot.
  always_comb begin
    empty     = (level_q == '0);
    full      = (level_q == LW'(DEPTH));
    pop_ok    = pop && !empty;
    push_ok   = push && (!full || pop_ok);
    wr_ptr_d  = wr_ptr_q + AW'(push_ok);
    rd_ptr_d  = rd_ptr_q + AW'(pop_ok);
    level_d   = level_q + LW'(push_ok) - LW'(pop_ok);
    overrun_d = overrun_q || (push && !push_ok);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      level_q   <= '0;
      overrun_q <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      level_q   <= level_d;
      overrun_q <= overrun_d;
    end
  end

  // Storage holds data only; level gates its visibility, so no reset needed.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= din;
  end

  assign dout    = empty ? SND_EMPTY_BYTE : mem_q[rd_ptr_q];
  assign level   = level_q;
  assign overrun = overrun_q;

endmodule

// File: rtl/jtmx5k_snd_comm.sv
// Main-to-sound CPU command channel: edge-detected strobes feed the command
// FIFO, and a small FSM raises one sound-CPU interrupt per queued byte.
module jtmx5k_snd_comm
  import jtmx5k_pkg::*;
#(
  parameter int DEPTH = SND_DEPTH_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   snd_irq,
  input  logic [7:0]             snd_latch,
  input  logic                   latch_rd,
  input  logic                   m1_n,
  input  logic                   iorq_n,
  output logic [7:0]             dout,
  output logic                   int_n,
  output logic [$clog2(DEPTH):0] level,
  output logic                   overrun
);

  logic       irq_q, irq_d;
  logic       rd_q, rd_d;
  logic       iack_q, iack_d;
  logic       int_n_q, int_n_d;
  int_state_e state_q, state_d;
  logic       iack, iack_rise, push, pop, has_data;

  always_comb begin
    iack      = !m1_n && !iorq_n;
    push      = snd_irq && !irq_q;
    pop       = rd_q && !latch_rd;
    iack_rise = iack && !iack_q;
    has_data  = (level != '0);
    irq_d     = snd_irq;
    rd_d      = latch_rd;
    iack_d    = iack;
  end

  // A pop wins over a simultaneous acknowledge; a pop straight from REQ is a
  // polled read that never saw the interrupt acknowledge cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      INT_IDLE:  if (has_data) state_d = INT_REQ;
      INT_REQ: begin
        if (pop)            state_d = INT_IDLE;
        else if (iack_rise) state_d = INT_ACKED;
      end
      INT_ACKED: if (pop) state_d = INT_IDLE;
      default:   state_d = INT_IDLE;
    endcase
    int_n_d = (state_q != INT_REQ);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      irq_q   <= 1'b0;
      rd_q    <= 1'b0;
      iack_q  <= 1'b0;
      int_n_q <= 1'b1;
      state_q <= INT_IDLE;
    end else begin
      irq_q   <= irq_d;
      rd_q    <= rd_d;
      iack_q  <= iack_d;
      int_n_q <= int_n_d;
      state_q <= state_d;
    end
  end

  jtmx5k_cmd_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (push),
    .pop     (pop),
    .din     (snd_latch),
    .dout    (dout),
    .level   (level),
    .overrun (overrun)
  );

  assign int_n = int_n_q;

endmodule
